// File: rtl/tile_pkg.sv
// tile_pkg: shared widths, rounding/saturation helper and FSM state type for the convolution stage.
package tile_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} conv_state_e;
    function automatic int prod_w(input int dw, input int cw);
        return dw + cw + 1;
    endfunction
    function automatic int acc_w(input int dw, input int cw, input int ws);
        return dw + cw + 1 + $clog2(ws * ws);
    endfunction
    // Round half up, arithmetic shift, then clamp into the unsigned output range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int shift, input int out_w);
        logic signed [63:0] r, mx;
        r = (shift > 0) ? (acc + (64'sd1 <<< (shift - 1))) >>> shift : acc;
        mx = (64'sd1 <<< out_w) - 64'sd1;
        return (r < 0) ? '0 : ((r > mx) ? mx : r);
    endfunction
endpackage

// File: rtl/tile_conv_vec_if.sv
// tile_conv_vec_if: coefficient, window and output-pixel handshake bundle.
interface tile_conv_vec_if #(
    parameter int DATA_W = 8,
    parameter int WIN_SIZE = 3,
    parameter int PIX_PER_CLK = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W = 8
);
    logic coef_valid, coef_ready, in_valid, in_ready, out_valid, out_ready, kernel_loaded;
    logic signed [COEF_W-1:0] coef_data;
    logic [DATA_W-1:0] window [PIX_PER_CLK][WIN_SIZE][WIN_SIZE];
    logic [OUT_W*PIX_PER_CLK-1:0] out_pixels;
    modport slave (
        input coef_valid, coef_data, in_valid, window, out_ready,
        output coef_ready, in_ready, out_valid, out_pixels, kernel_loaded
    );
    modport master (
        output coef_valid, coef_data, in_valid, window, out_ready,
        input coef_ready, in_ready, out_valid, out_pixels, kernel_loaded
    );
endinterface

// File: rtl/conv_lane_dot.sv
// conv_lane_dot: one lane's window-by-kernel products (S1) and adder tree (S2).
module conv_lane_dot import tile_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int WIN_SIZE = 3,
    parameter int COEF_W = 8,
    localparam int TAPS = WIN_SIZE * WIN_SIZE,
    localparam int PROD_W = prod_w(DATA_W, COEF_W),
    localparam int ACC_W = acc_w(DATA_W, COEF_W, WIN_SIZE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic [DATA_W-1:0] pix [WIN_SIZE][WIN_SIZE],
    input  logic signed [COEF_W-1:0] coef [TAPS],
    output logic signed [ACC_W-1:0] acc
);
    logic signed [PROD_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0] sum;
    always_comb begin
        sum = '0;
        for (int t = 0; t < TAPS; t++) sum += ACC_W'(prod[t]);
    end
    // Pixels are unsigned, so a zero sign bit is prepended before the signed multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TAPS; t++) prod[t] <= '0;
            acc <= '0;
        end else if (en) begin
            for (int t = 0; t < TAPS; t++)
                prod[t] <= PROD_W'($signed({1'b0, pix[t / WIN_SIZE][t % WIN_SIZE]})) * PROD_W'(coef[t]);
            acc <= sum;
        end
    end
endmodule

// File: rtl/tile_conv_vec.sv
// tile_conv_vec: vectorised 2-D convolution with serial kernel load and a 3-stage stallable pipeline.
module tile_conv_vec import tile_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int WIN_SIZE = 3,
    parameter int PIX_PER_CLK = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input logic clk,
    input logic rst_n,
    tile_conv_vec_if.slave io
);
    localparam int TAPS = WIN_SIZE * WIN_SIZE;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, WIN_SIZE);
    localparam int CNT_W = $clog2(TAPS + 1);
    conv_state_e state;
    logic [CNT_W-1:0] cnt;
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0] acc [PIX_PER_CLK];
    logic [OUT_W-1:0] sat [PIX_PER_CLK];
    logic v1, v2, pipe_en, coef_fire;
    assign pipe_en = !io.out_valid || io.out_ready;
    assign io.in_ready = state == RUN && pipe_en;
    assign io.coef_ready = state == IDLE || state == LOAD;
    assign coef_fire = io.coef_valid && io.coef_ready;
    // Kernel writes only happen in IDLE/LOAD, which are reachable solely with an empty pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            io.kernel_loaded <= 1'b0;
            for (int t = 0; t < TAPS; t++) coef[t] <= '0;
        end else begin
            unique case (state)
                IDLE, LOAD: if (coef_fire) begin
                    coef[cnt] <= io.coef_data;
                    cnt <= (cnt == CNT_W'(TAPS - 1)) ? '0 : cnt + CNT_W'(1);
                    io.kernel_loaded <= cnt == CNT_W'(TAPS - 1);
                    state <= (cnt == CNT_W'(TAPS - 1)) ? RUN : LOAD;
                end
                RUN: if (io.coef_valid && !io.in_valid) begin
                    state <= DRAIN;
                    io.kernel_loaded <= 1'b0;
                end
                DRAIN: if (!v1 && !v2 && !io.out_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < PIX_PER_CLK; g++) begin : g_lane
        conv_lane_dot #(.DATA_W(DATA_W), .WIN_SIZE(WIN_SIZE), .COEF_W(COEF_W)) u_dot (
            .clk(clk),
            .rst_n(rst_n),
            .en(pipe_en),
            .pix(io.window[g]),
            .coef(coef),
            .acc(acc[g])
        );
        assign sat[g] = OUT_W'(sat_round(64'(acc[g]), SHIFT, OUT_W));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_pixels <= '0;
        end else if (pipe_en) begin
            v1 <= io.in_valid && io.in_ready;
            v2 <= v1;
            io.out_valid <= v2;
            for (int p = 0; p < PIX_PER_CLK; p++) io.out_pixels[p*OUT_W +: OUT_W] <= sat[p];
        end
    end
endmodule
